// File: rtl/synchronous_up_counter_pkg.sv
// Shared constants and helpers for the synchronous up counter.
// The default width and the all-ones terminal value live here so the top
// module and any future users compute them the same way.
package synchronous_up_counter_pkg;

  // Default counter width and the range the design is meant to support.
  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  // All-ones value for a counter of the given width, right-aligned in a
  // MAX_WIDTH-bit word. Shifting a full word right avoids the 1 << 32
  // overflow that "2**width - 1" would hit at the widest setting.
  function automatic logic [MAX_WIDTH-1:0] terminal_value(input int width);
    logic [MAX_WIDTH-1:0] ones;
    ones = {MAX_WIDTH{1'b1}};
    return ones >> (MAX_WIDTH - width);
  endfunction

endpackage : synchronous_up_counter_pkg

// File: rtl/synchronous_up_counter_sync_tff.sv
// Single toggle flip-flop with synchronous, active-high clear.
// One instance per counter bit; the top module supplies the toggle enable.
module sync_tff (
  input  logic clk,
  input  logic reset_n,
  input  logic t,
  output logic q
);

  // Clear on reset, otherwise invert the stored bit whenever t is high.
  // NOTE: state is updated with non-blocking assignments and reset is only
  // looked at inside the clocked branch, so it has no effect between edges.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule : sync_tff

// File: rtl/synchronous_up_counter.sv
// Fully synchronous binary up counter built from toggle flip-flops.
// Every bit is clocked by clk; bit i toggles when all lower bits are 1.
// tc flags the all-ones state combinationally; wrap is a registered pulse
// in the cycle after the count rolls over from all ones to zero.
// reset_n is a synchronous reset asserted when high (name kept for
// compatibility with the surrounding codebase).
module synchronous_up_counter
  import synchronous_up_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // legal range MIN_WIDTH..MAX_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  // Count value at which the next non-reset edge rolls over to zero.
  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(terminal_value(WIDTH));

  // Per-bit toggle enables: the carry chain of the counter.
  logic [WIDTH-1:0] toggle;

  // Bit 0 always toggles; bit i toggles when bits 0..i-1 are all ones.
  // Each enable is the AND of every lower bit, which is the same chain as
  // toggle[i-1] & Q[i-1] without a self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign toggle[i] = 1'b1;
    end else begin : g_upper
      assign toggle[i] = &Q[i-1:0];
    end

    sync_tff u_tff (
      .clk     (clk),
      .reset_n (reset_n),
      .t       (toggle[i]),
      .q       (Q[i])
    );
  end

  // Terminal count: high while the counter holds all ones.
  assign tc = (Q == TERMINAL);

  // Rollover pulse: a non-reset edge taken while tc is high loads zero, so
  // registering tc on that edge marks exactly the cycle after the wrap.
  // Reset wins, so asserting it at all ones leaves wrap low.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule : synchronous_up_counter

// File: tb/tb_synchronous_up_counter.sv
// Self-checking bench for synchronous_up_counter at WIDTH=4 and WIDTH=8.
// A behavioural model (plain modular arithmetic) predicts Q, tc and wrap.
module tb_synchronous_up_counter;

  logic       clk;
  logic       rst4;
  logic       rst8;
  logic [3:0] q4;
  logic       tc4;
  logic       wrap4;
  logic [7:0] q8;
  logic       tc8;
  logic       wrap8;

  int n_tests;
  int n_fail;

  // Reference model state.
  int m4_q;
  bit m4_w;
  int m8_q;
  bit m8_w;

  synchronous_up_counter #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset_n (rst4),
    .Q       (q4),
    .tc      (tc4),
    .wrap    (wrap4)
  );

  synchronous_up_counter #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset_n (rst8),
    .Q       (q8),
    .tc      (tc8),
    .wrap    (wrap8)
  );

  // 50 ns clock period.
  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Counter behaviour: reset clears, otherwise count modulo 'modulus';
  // wrap is set for the cycle following a step out of modulus-1.
  function automatic void model_step(input bit rst, input int modulus,
                                     inout int q, inout bit w);
    if (rst) begin
      q = 0;
      w = 1'b0;
    end else begin
      w = (q == modulus - 1);
      q = (q + 1) % modulus;
    end
  endfunction

  // Advance one rising edge, update both models, then settle before sampling.
  task automatic edge_all();
    @(posedge clk);
    model_step(rst4, 16, m4_q, m4_w);
    model_step(rst8, 256, m8_q, m8_w);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1;
    rst8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      edge_all();
      n_tests++;
      if ({q4, tc4, wrap4} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset4 q=%0d tc=%b wrap=%b expected q=0 tc=0 wrap=0", q4, tc4, wrap4);
      end
      n_tests++;
      if ({q8, tc8, wrap8} !== {8'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset8 q=%0d tc=%b wrap=%b expected q=0 tc=0 wrap=0", q8, tc8, wrap8);
      end
    end
    rst4 = 1'b0;
    rst8 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      edge_all();
      n_tests++;
      if (q4 !== 4'(k)) begin
        n_fail++;
        $display("FAIL post_reset_count q=%0d expected %0d", q4, k);
      end
    end
  endtask

  // Full cycle from zero: every step, tc only at 15, wrap after rollover.
  task automatic test_full_cycle();
    rst4 = 1'b1;
    edge_all();
    rst4 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      edge_all();
      n_tests++;
      if ({q4, tc4, wrap4} !== {4'(m4_q), m4_q == 15, m4_w}) begin
        n_fail++;
        $display("FAIL full_cycle step=%0d q=%0d tc=%b wrap=%b expected q=%0d tc=%b wrap=%b",
                 k, q4, tc4, wrap4, m4_q, m4_q == 15, m4_w);
      end
    end
  endtask

  // 30-edge window after reset: 1..15, 0..14 with exactly one wrap pulse.
  task automatic test_window();
    int wraps;
    wraps = 0;
    rst4 = 1'b1;
    edge_all();
    rst4 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      edge_all();
      if (wrap4 === 1'b1) wraps++;
      n_tests++;
      if (q4 !== 4'(k % 16)) begin
        n_fail++;
        $display("FAIL window edge=%0d q=%0d expected %0d", k, q4, k % 16);
      end
    end
    n_tests++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL window_wraps count=%0d expected 1", wraps);
    end
  endtask

  // Reset asserted for one edge at Q=9 (mid-count) and at Q=15 (terminal).
  task automatic test_reset_mid_and_terminal();
    int stops[2];
    stops[0] = 9;
    stops[1] = 15;
    for (int s = 0; s < 2; s++) begin
      rst4 = 1'b1;
      edge_all();
      rst4 = 1'b0;
      for (int k = 0; k < stops[s]; k++) edge_all();
      n_tests++;
      if (q4 !== 4'(stops[s])) begin
        n_fail++;
        $display("FAIL reset_setup q=%0d expected %0d", q4, stops[s]);
      end
      rst4 = 1'b1;
      edge_all();
      rst4 = 1'b0;
      n_tests++;
      if ({q4, tc4, wrap4} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_at_%0d q=%0d tc=%b wrap=%b expected q=0 tc=0 wrap=0",
                 stops[s], q4, tc4, wrap4);
      end
      edge_all();
      n_tests++;
      if ({q4, wrap4} !== {4'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL after_reset_at_%0d q=%0d wrap=%b expected q=1 wrap=0",
                 stops[s], q4, wrap4);
      end
    end
  endtask

  // Reset pulses strictly between edges must not disturb any output.
  task automatic test_reset_between_edges();
    for (int r = 0; r < 6; r++) begin
      logic [3:0] h4;
      logic [7:0] h8;
      logic       ht4;
      logic       hw4;
      logic       hw8;
      h4  = q4;
      h8  = q8;
      ht4 = tc4;
      hw4 = wrap4;
      hw8 = wrap8;
      #($urandom_range(2, 10));
      rst4 = 1'b1;
      rst8 = 1'b1;
      #($urandom_range(2, 10));
      n_tests++;
      if ({q4, tc4, wrap4, q8, wrap8} !== {h4, ht4, hw4, h8, hw8}) begin
        n_fail++;
        $display("FAIL async_assert q4=%0d q8=%0d expected q4=%0d q8=%0d", q4, q8, h4, h8);
      end
      rst4 = 1'b0;
      rst8 = 1'b0;
      #($urandom_range(2, 10));
      n_tests++;
      if ({q4, tc4, wrap4, q8, wrap8} !== {h4, ht4, hw4, h8, hw8}) begin
        n_fail++;
        $display("FAIL async_release q4=%0d q8=%0d expected q4=%0d q8=%0d", q4, q8, h4, h8);
      end
      edge_all();
      n_tests++;
      if ({q4, q8} !== {4'(m4_q), 8'(m8_q)}) begin
        n_fail++;
        $display("FAIL edge_after_glitch q4=%0d q8=%0d expected q4=%0d q8=%0d",
                 q4, q8, m4_q, m8_q);
      end
    end
  endtask

  // WIDTH=8: full 256-step run, wrap from 255 to 0 seen exactly once.
  task automatic test_wide_wrap();
    int wraps;
    wraps = 0;
    rst8 = 1'b1;
    edge_all();
    rst8 = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      edge_all();
      if (wrap8 === 1'b1) wraps++;
      n_tests++;
      if ({q8, tc8, wrap8} !== {8'(m8_q), m8_q == 255, m8_w}) begin
        n_fail++;
        $display("FAIL wide step=%0d q=%0d tc=%b wrap=%b expected q=%0d tc=%b wrap=%b",
                 k, q8, tc8, wrap8, m8_q, m8_q == 255, m8_w);
      end
    end
    n_tests++;
    if ({q8, wrap8, wraps == 1} !== {8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_wrap q=%0d wrap=%b pulses=%0d expected q=0 wrap=1 pulses=1",
               q8, wrap8, wraps);
    end
  endtask

  // Random reset pattern on both counters against the model.
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst4 = ($urandom_range(0, 15) == 0);
      rst8 = ($urandom_range(0, 31) == 0);
      edge_all();
      n_tests++;
      if ({q4, tc4, wrap4} !== {4'(m4_q), m4_q == 15, m4_w}) begin
        n_fail++;
        $display("FAIL random4 step=%0d q=%0d tc=%b wrap=%b expected q=%0d tc=%b wrap=%b",
                 k, q4, tc4, wrap4, m4_q, m4_q == 15, m4_w);
      end
      n_tests++;
      if ({q8, tc8, wrap8} !== {8'(m8_q), m8_q == 255, m8_w}) begin
        n_fail++;
        $display("FAIL random8 step=%0d q=%0d tc=%b wrap=%b expected q=%0d tc=%b wrap=%b",
                 k, q8, tc8, wrap8, m8_q, m8_q == 255, m8_w);
      end
    end
    rst4 = 1'b0;
    rst8 = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m4_q    = 0;
    m4_w    = 1'b0;
    m8_q    = 0;
    m8_w    = 1'b0;
    rst4    = 1'b1;
    rst8    = 1'b1;
    test_reset();
    test_full_cycle();
    test_window();
    test_reset_mid_and_terminal();
    test_reset_between_edges();
    test_wide_wrap();
    test_reset_between_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_synchronous_up_counter

// File: doc/synchronous_up_counter.md
SYNCHRONOUS_UP_COUNTER -- requirements
Module: synchronous_up_counter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-003 Port clk, input, 1: sole clock; all state SHALL change only on its rising edge.
REQ-004 Port reset_n, input, 1: synchronous reset, asserted when 1; the name follows the codebase convention, not the polarity.
REQ-005 Port Q, output, WIDTH: current count value, driven directly from registers.
REQ-006 Port tc, output, 1: terminal count, high combinationally while Q equals all ones.
REQ-007 Port wrap, output, 1: registered one-cycle pulse, high in the cycle after Q went from all ones to zero.
REQ-008 Port order SHALL be clk, reset_n, Q, tc, wrap, so a positional three-port instantiation remains legal.

Function
REQ-009 When reset_n = 0 at a rising clk edge, Q SHALL increment by 1 modulo 2^WIDTH.
REQ-010 Increment latency is one edge: the new value SHALL be visible on Q after the same edge that sampled it.
REQ-011 At Q = 2^WIDTH-1, the next non-reset edge SHALL load 0; no saturation and no stall.
REQ-012 tc SHALL equal 1 exactly when Q = 2^WIDTH-1 (15 for WIDTH=4), else 0.
REQ-013 wrap SHALL be 1 for exactly one cycle after each all-ones-to-zero transition, else 0.
REQ-014 Counting SHALL be fully synchronous: every bit SHALL be clocked by clk, and no bit SHALL be clocked by another bit.
REQ-015 Bit i SHALL toggle iff bits 0..i-1 are all 1 (T-flip-flop carry-chain form); bit 0 SHALL toggle every non-reset edge.
REQ-016 Before the first reset edge, Q is don't-care; X-free behaviour is required only after reset.

Reset
REQ-017 reset_n = 1 at a rising edge SHALL force Q = 0, wrap = 0; tc then reads 0.
REQ-018 Reset SHALL take priority over counting, including when asserted mid-count or at Q = all ones; in the latter case wrap SHALL stay 0.
REQ-019 Reset SHALL have no asynchronous effect: asserting or deasserting it between edges SHALL NOT change any output.
REQ-020 After reset deasserts, the first non-reset edge SHALL produce Q = 1.

Structure
REQ-021 A shared package SHALL hold the default WIDTH constant and a function computing the all-ones terminal value for a given width.
REQ-022 One sub-module, sync_tff (inputs clk, reset_n, t; output q; synchronous active-high clear), SHALL be instantiated WIDTH times via generate.
REQ-023 The toggle-enable AND chain and the tc/wrap logic SHALL live in the top module.

Verification
REQ-024 Hold reset_n = 1 for 2 edges (period 50 ns), then 0: Q = 0 during reset; Q = 1, 2, 3 on the next three edges.
REQ-025 Run 16 edges from 0: Q steps 0..15; tc = 1 only at Q = 15; the next edge gives Q = 0 with wrap = 1 for one cycle.
REQ-026 Run 30 edges after reset (the 1500 ns window): Q sequence 1..15, 0..14 with no skips; wrap pulses once.
REQ-027 Assert reset_n = 1 at Q = 9 for one edge: Q = 0 on that edge, then 1 on the next.
REQ-028 Assert reset at Q = 15: Q = 0, wrap stays 0.
REQ-029 Toggle reset_n between edges only: Q is unchanged until the next edge; repeat at WIDTH = 8 and check the wrap from 255 to 0.
